// File: rtl/usb_tx_arbiter_if.sv
// Byte-pipe bundle between two requesters (A = CPU, B = debug) and the USB UART input.
// Latency: none (wires only).
// Backpressure: carried by a_ready / b_ready / uart_in_ready.
// Ports: a_* / b_* requester byte streams with last flag, uart_in_* output byte stream.
// Modports: slave = arbiter view, master = requesters plus UART (environment) view.
interface usb_tx_arbiter_if;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_last;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_last;
  logic       b_ready;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;

  modport slave (
    input  a_data, a_valid, a_last,
    output a_ready,
    input  b_data, b_valid, b_last,
    output b_ready,
    output uart_in_data, uart_in_valid,
    input  uart_in_ready
  );

  modport master (
    output a_data, a_valid, a_last,
    input  a_ready,
    output b_data, b_valid, b_last,
    input  b_ready,
    input  uart_in_data, uart_in_valid,
    output uart_in_ready
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing the USB UART byte pipe between requesters A and B.
// Latency: grant 1 cycle after valid seen in IDLE; byte appears on uart_in_* 1 cycle after accept.
// Backpressure: owner ready = ~uart_in_valid | uart_in_ready, so full rate with no bubbles while the UART is ready.
// Ports: clk, rst (async active-low), bus (slave modport), grant (one-hot owner), timeout_evt (forced-release pulse).
module usb_tx_arbiter #(
  parameter int TIMEOUT   = 1000,
  parameter int TIMEOUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  usb_tx_arbiter_if.slave  bus,
  output logic [1:0]       grant,
  output logic             timeout_evt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // Counter value at which one more idle cycle means the owner has been idle for TIMEOUT cycles.
  localparam logic [TIMEOUT_W-1:0] CNT_LIMIT =
    (TIMEOUT == 0) ? {TIMEOUT_W{1'b0}} : TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 last_owner_b_q, last_owner_b_d;
  logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [7:0]           out_data_q;
  logic                 out_vld_q;

  logic       own_valid;
  logic [7:0] own_data;
  logic       own_last;
  logic       pipe_free;
  logic       accept;
  logic       idle_expire;

  // Select the current owner's stream; a non-owner never reaches the output register.
  always_comb begin
    own_valid = 1'b0;
    own_data  = 8'h00;
    own_last  = 1'b0;
    unique case (state_q)
      GNT_A: begin
        own_valid = bus.a_valid;
        own_data  = bus.a_data;
        own_last  = bus.a_last;
      end
      GNT_B: begin
        own_valid = bus.b_valid;
        own_data  = bus.b_data;
        own_last  = bus.b_last;
      end
      default: ;
    endcase
  end

  assign pipe_free   = ~out_vld_q | bus.uart_in_ready;
  assign bus.a_ready = (state_q == GNT_A) & pipe_free;
  assign bus.b_ready = (state_q == GNT_B) & pipe_free;
  assign accept      = own_valid & pipe_free;

  // Only cycles where the owner offers nothing age the grant; stalled bytes do not.
  assign idle_expire = (TIMEOUT != 0) && (state_q != IDLE) && !own_valid &&
                       (idle_cnt_q == CNT_LIMIT);

  always_comb begin
    state_d        = state_q;
    last_owner_b_d = last_owner_b_q;
    idle_cnt_d     = idle_cnt_q;
    timeout_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Holding the counter at zero here clears it on every grant entry.
        idle_cnt_d = '0;
        if (bus.a_valid && (!bus.b_valid || last_owner_b_q)) begin
          state_d = GNT_A;
        end else if (bus.b_valid) begin
          state_d = GNT_B;
        end
      end
      default: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (own_last) begin
            state_d        = IDLE;
            last_owner_b_d = (state_q == GNT_B);
          end
        end else if (!own_valid) begin
          if (idle_expire) begin
            state_d        = IDLE;
            last_owner_b_d = (state_q == GNT_B);
            timeout_d      = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + TIMEOUT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_owner_b_q <= 1'b1;
      idle_cnt_q     <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_b_q <= last_owner_b_d;
      idle_cnt_q     <= idle_cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  // Single output stage: load on accept, drain on UART ready, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q <= 8'h00;
      out_vld_q  <= 1'b0;
    end else if (accept) begin
      out_data_q <= own_data;
      out_vld_q  <= 1'b1;
    end else if (bus.uart_in_ready) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign bus.uart_in_data  = out_data_q;
  assign bus.uart_in_valid = out_vld_q;
  assign grant             = {state_q == GNT_B, state_q == GNT_A};
  assign timeout_evt       = timeout_q;

endmodule
